imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 10'd0: instruction-memory word address of the first loaded word.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port START  input  1  begin a load session; sampled only in IDLE, DONE, ERROR.
REQ-005 SHALL have port RX_DATA  input  8  incoming byte.
REQ-006 SHALL have port RX_VALID  input  1  RX_DATA valid.
REQ-007 SHALL have port RX_READY  output  1  loader accepts a byte.
REQ-008 SHALL have port MEM_ADDRESS  output  10  word address of the write.
REQ-009 SHALL have port MEM_DATA  output  32  instruction word to write.
REQ-010 SHALL have port MEM_WE  output  1  write strobe, one cycle per word.
REQ-011 SHALL have port CPU_HOLD  output  1  keeps the core in reset while a load is in progress.
REQ-012 SHALL have port DONE  output  1  last session completed with a good checksum.
REQ-013 SHALL have port ERROR  output  1  last session failed (bad count or checksum).
REQ-014 SHALL have port WORDS_WRITTEN  output  11  words written in the current or last session.

Function
REQ-015 SHALL accept a byte only at a rising edge where RX_VALID=1 and RX_READY=1; RX_DATA is ignored at all other edges.
REQ-016 SHALL implement states IDLE, HDR_LO, HDR_HI, PAYLOAD, CHECK, DONE, ERROR, with RX_READY=1 exactly in HDR_LO, HDR_HI, PAYLOAD and CHECK.
REQ-017 SHALL transition IDLE/DONE/ERROR -> HDR_LO on START=1, clearing DONE, ERROR and WORDS_WRITTEN, setting CPU_HOLD=1, loading the address counter with BASE_ADDRESS and clearing the checksum; START in any other state is ignored.
REQ-018 SHALL form the word count N from the accepted bytes as {HDR_HI byte, HDR_LO byte}, taking the HDR_LO byte first.
REQ-019 SHALL, after accepting the HDR_HI byte, go to ERROR if N=0 or N>1024, else to PAYLOAD.
REQ-020 SHALL assemble each payload word little-endian: first byte is bits 7:0, fourth byte is bits 31:24.
REQ-021 SHALL, at the edge accepting a word's fourth byte, register MEM_DATA=word and MEM_ADDRESS=current address, and raise MEM_WE for exactly that following cycle.
REQ-022 SHALL hold MEM_WE=0 in every cycle except those in REQ-021.
REQ-023 SHALL increment the address counter modulo 1024 after each write, so address 1023 is followed by 0.
REQ-024 SHALL increment WORDS_WRITTEN with each MEM_WE and go to CHECK after the N-th word.
REQ-025 SHALL keep a running 8-bit XOR of all 4N payload bytes.
REQ-026 SHALL, in CHECK, compare the accepted byte to the XOR, going to DONE (DONE=1) on a match, else to ERROR (ERROR=1).
REQ-027 SHALL leave already-written words written when a checksum fails; no rollback occurs.
REQ-028 SHALL drop CPU_HOLD to 0 on entering DONE, and keep it at 1 in ERROR until the next START completes successfully or reset.
REQ-029 SHALL tolerate arbitrary RX_VALID gaps with identical results; no timeout applies.
REQ-030 SHALL keep MEM_ADDRESS and MEM_DATA at their last written values when MEM_WE=0.

Reset
REQ-031 SHALL, while RST_N=0 (independent of CLK), force state IDLE, RX_READY=0, MEM_WE=0, MEM_ADDRESS=0, MEM_DATA=0, CPU_HOLD=0, DONE=0, ERROR=0, WORDS_WRITTEN=0, checksum=0, and clear any partial word.
REQ-032 SHALL, on reset asserted mid-session, abandon the session with no further MEM_WE, and require a new START afterwards.

Verification
REQ-033 SHALL be verified with this case: BASE_ADDRESS=0, START, bytes 01 00 93 00 10 00 83 -> one MEM_WE with MEM_ADDRESS=0, MEM_DATA=0x00100093, then DONE=1, ERROR=0, CPU_HOLD=0, WORDS_WRITTEN=1.
REQ-034 SHALL be verified with this case: same stream but checksum byte 84 -> MEM_WE pulses once, then ERROR=1, DONE=0, CPU_HOLD=1.
REQ-035 SHALL be verified with this case: header 00 00, then header 01 04 (N=1025) -> ERROR=1 right after HDR_HI, no MEM_WE, RX_READY=0.
REQ-036 SHALL be verified with this case: BASE_ADDRESS=1023, N=2, words 0x00000013 and 0x00100313 with the correct XOR -> writes at addresses 1023 then 0, then DONE=1, WORDS_WRITTEN=2.
REQ-037 SHALL be verified with this case: the REQ-033 stream with RX_VALID low on alternate cycles and START pulsed during PAYLOAD -> results identical to REQ-033, START ignored.
REQ-038 SHALL be verified with this case: RST_N low asynchronously after two payload bytes -> all outputs reach reset values before the next edge, no MEM_WE, and a fresh REQ-033 session then succeeds.

Source files
------------

// File: rtl/imem_loader.sv
// Serial instruction-memory loader: takes a framed byte stream (16-bit word count,
// little-endian payload words, XOR checksum) and writes words into the core's IMEM.
module imem_loader #(
    parameter logic [9:0] BASE_ADDRESS = 10'd0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [9:0]  MEM_ADDRESS,
    output logic [31:0] MEM_DATA,
    output logic        MEM_WE,
    output logic        CPU_HOLD,
    output logic        DONE,
    output logic        ERROR,
    output logic [10:0] WORDS_WRITTEN
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_LO  = 3'd1,
        ST_HDR_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_lo_q, count_lo_d;
    logic [10:0] count_q, count_d;
    logic [9:0]  addr_q, addr_d;
    logic [23:0] buf_q, buf_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [10:0] words_q, words_d;
    logic [9:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mem_we_q, mem_we_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        ready_q, ready_d;
    logic        accept_s;
    logic [15:0] hdr_s;

    assign accept_s = RX_VALID & ready_q;
    assign hdr_s    = {RX_DATA, count_lo_q};

    // Next-state, datapath and status decode for the load session.
    always_comb begin
        state_d    = state_q;
        count_lo_d = count_lo_q;
        count_d    = count_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        words_d    = words_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        hold_d     = hold_q;
        done_d     = done_q;
        error_d    = error_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (START) begin
                    state_d = ST_HDR_LO;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    words_d = 11'd0;
                    hold_d  = 1'b1;
                    addr_d  = BASE_ADDRESS;
                    csum_d  = 8'd0;
                    idx_d   = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HDR_LO: begin
                if (accept_s) begin
                    count_lo_d = RX_DATA;
                    state_d    = ST_HDR_HI;
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_HI: begin
                if (accept_s) begin
                    if ((hdr_s == 16'd0) || (hdr_s > 16'd1024)) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                        count_d = hdr_s[10:0];
                    end
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_PAYLOAD: begin
                if (accept_s) begin
                    csum_d = csum_q ^ RX_DATA;
                    case (idx_q)
                        2'd0:    buf_d[7:0]   = RX_DATA;
                        2'd1:    buf_d[15:8]  = RX_DATA;
                        2'd2:    buf_d[23:16] = RX_DATA;
                        default: buf_d        = buf_q;
                    endcase
                    if (idx_q == 2'd3) begin
                        // Fourth byte completes the word: write it and advance (address wraps at 1024).
                        mem_we_d   = 1'b1;
                        mem_data_d = {RX_DATA, buf_q};
                        mem_addr_d = addr_q;
                        addr_d     = addr_q + 10'd1;
                        words_d    = words_q + 11'd1;
                        idx_d      = 2'd0;
                        if ((words_q + 11'd1) == count_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (RX_DATA == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_HDR_LO) || (state_d == ST_HDR_HI) ||
                  (state_d == ST_PAYLOAD) || (state_d == ST_CHECK);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            count_lo_q <= 8'd0;
            count_q    <= 11'd0;
            addr_q     <= 10'd0;
            buf_q      <= 24'd0;
            idx_q      <= 2'd0;
            csum_q     <= 8'd0;
            words_q    <= 11'd0;
            mem_addr_q <= 10'd0;
            mem_data_q <= 32'd0;
            mem_we_q   <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_lo_q <= count_lo_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            words_q    <= words_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
        end
    end

    assign RX_READY      = ready_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_DATA      = mem_data_q;
    assign MEM_WE        = mem_we_q;
    assign CPU_HOLD      = hold_q;
    assign DONE          = done_q;
    assign ERROR         = error_q;
    assign WORDS_WRITTEN = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0 and base 1023) share one
// byte stream; results are checked against a word-list reference model.
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  RX_DATA = 8'd0;
    logic        RX_VALID = 1'b0;
    logic        rdy0, we0, hold0, done0, err0, rdy1, we1, hold1, done1, err1;
    logic [9:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic [10:0] ww0, ww1;

    imem_loader #(.BASE_ADDRESS(10'd0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(rdy0), .MEM_ADDRESS(addr0), .MEM_DATA(data0), .MEM_WE(we0),
        .CPU_HOLD(hold0), .DONE(done0), .ERROR(err0), .WORDS_WRITTEN(ww0));

    imem_loader #(.BASE_ADDRESS(10'd1023)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(rdy1), .MEM_ADDRESS(addr1), .MEM_DATA(data1), .MEM_WE(we1),
        .CPU_HOLD(hold1), .DONE(done1), .ERROR(err1), .WORDS_WRITTEN(ww1));

    always #5 CLK = ~CLK;

    typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
    wr_t q0[$];
    wr_t q1[$];

    // Record every write strobe, sampled mid-cycle.
    always @(negedge CLK) begin
        if (we0 === 1'b1) q0.push_back('{addr0, data0});
        if (we1 === 1'b1) q1.push_back('{addr1, data1});
    end

    int tests = 0;
    int fails = 0;
    int gap_mode = 0;
    logic [31:0] words [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge CLK); RST_N = 1'b0; START = 1'b0; RX_VALID = 1'b0;
        @(negedge CLK); @(negedge CLK); RST_N = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        int k;
        gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gap; g++) begin
            @(negedge CLK); RX_VALID = 1'b0; RX_DATA = 8'($urandom);
        end
        @(negedge CLK); RX_VALID = 1'b1; RX_DATA = b;
        k = 0;
        while (rdy0 !== 1'b1 && k < 50) begin
            @(negedge CLK); k++;
        end
        if (k == 50) begin
            tests++; fails++;
            $display("FAIL rx_ready_timeout: got RX_READY=0 for 50 cycles expected 1");
            RX_VALID = 1'b0;
        end else begin
            @(posedge CLK); #1;
            RX_VALID = 1'b0; RX_DATA = 8'($urandom);
        end
    endtask

    function automatic logic [7:0] model_xor(input int n);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < n; i++)
            x ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
        return x;
    endfunction

    // One full session driven on both instances and compared against the model.
    task automatic run_session(input int n, input logic [7:0] cs, input bit start_mid);
        logic good;
        logic [15:0] nn;
        nn = 16'(n);
        q0.delete(); q1.delete();
        pulse_start();
        send_byte(nn[7:0]);
        send_byte(nn[15:8]);
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++) begin
                send_byte(words[i][8*b +: 8]);
                if (start_mid && i == 0 && b == 1) pulse_start();
            end
        send_byte(cs);
        @(negedge CLK);
        good = (cs == model_xor(n));
        chk("write_count0", q0.size(), n);
        chk("write_count1", q1.size(), n);
        for (int i = 0; i < n && i < q0.size() && i < q1.size(); i++) begin
            chk("addr0", 32'(q0[i].a), 32'((0 + i) % 1024));
            chk("data0", q0[i].d, words[i]);
            chk("addr1", 32'(q1[i].a), 32'((1023 + i) % 1024));
            chk("data1", q1[i].d, words[i]);
        end
        chk("done", 32'({done0, done1}), good ? 32'd3 : 32'd0);
        chk("error", 32'({err0, err1}), good ? 32'd0 : 32'd3);
        chk("cpu_hold", 32'({hold0, hold1}), good ? 32'd0 : 32'd3);
        chk("words_written0", 32'(ww0), 32'(n));
        chk("words_written1", 32'(ww1), 32'(n));
        chk("rx_ready_idle", 32'(rdy0), 32'd0);
    endtask

    typedef struct { logic [7:0] lo; logic [7:0] hi; logic exp_err; } hdr_vec_t;

    initial begin
        hdr_vec_t hv [0:5];
        int n;
        logic [7:0] cs;
        hv[0] = '{8'h00, 8'h00, 1'b1};
        hv[1] = '{8'h01, 8'h04, 1'b1};
        hv[2] = '{8'h00, 8'h04, 1'b0};
        hv[3] = '{8'h01, 8'h00, 1'b0};
        hv[4] = '{8'hFF, 8'h03, 1'b0};
        hv[5] = '{8'h00, 8'h80, 1'b1};

        #12;
        chk("reset_ready", 32'(rdy0), 32'd0);
        chk("reset_status", 32'({we0, hold0, done0, err0}), 32'd0);
        chk("reset_words", 32'(ww0), 32'd0);
        chk("reset_addr", 32'(addr1), 32'd0);
        RST_N = 1'b1;

        // Known-good single word, then bad checksum.
        words[0] = 32'h00100093;
        run_session(1, 8'h83, 1'b0);
        chk("basic_addr", 32'(q0.size() > 0 ? q0[0].a : 10'h3FF), 32'd0);
        chk("basic_data", q0.size() > 0 ? q0[0].d : 32'd0, 32'h00100093);
        chk("basic_done", 32'({done0, err0, hold0}), 32'b100);
        run_session(1, 8'h84, 1'b0);
        chk("badsum_status", 32'({done0, err0, hold0}), 32'b011);

        // Header range table.
        for (int t = 0; t < 6; t++) begin
            if (rdy0 === 1'b1) apply_reset();
            q0.delete();
            pulse_start();
            send_byte(hv[t].lo);
            send_byte(hv[t].hi);
            @(negedge CLK);
            chk("hdr_error", 32'(err0), 32'(hv[t].exp_err));
            chk("hdr_ready", 32'(rdy0), 32'(!hv[t].exp_err));
            chk("hdr_hold", 32'(hold0), 32'd1);
            chk("hdr_no_write", q0.size(), 0);
        end
        apply_reset();

        // Address wrap on the base-1023 instance with a two-word image.
        words[0] = 32'h00000013;
        words[1] = 32'h00100313;
        run_session(2, 8'h13, 1'b0);
        chk("wrap_addr_1", 32'(q1.size() > 1 ? q1[1].a : 10'h3FF), 32'd0);

        // Alternating RX_VALID gaps and a START pulse mid-payload.
        words[0] = 32'h00100093;
        gap_mode = 1;
        run_session(1, 8'h83, 1'b1);
        gap_mode = 0;

        // Asynchronous reset mid-payload, then a fresh session.
        q0.delete();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h93); send_byte(8'h00);
        @(negedge CLK); #1 RST_N = 1'b0; #1;
        chk("arst_ready", 32'(rdy0), 32'd0);
        chk("arst_we", 32'(we0), 32'd0);
        chk("arst_addr", 32'(addr0), 32'd0);
        chk("arst_data", data0, 32'd0);
        chk("arst_flags", 32'({hold0, done0, err0}), 32'd0);
        chk("arst_words", 32'(ww0), 32'd0);
        @(negedge CLK); @(negedge CLK); RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("arst_no_write", q0.size(), 0);
        chk("arst_needs_start", 32'(rdy0), 32'd0);
        run_session(1, 8'h83, 1'b0);

        // Randomized sessions with random gaps, some with corrupted checksums.
        gap_mode = 2;
        for (int s = 0; s < 10; s++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) words[i] = $urandom;
            cs = model_xor(n);
            if ($urandom_range(0, 2) == 0) cs ^= 8'($urandom_range(1, 255));
            run_session(n, cs, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
